posit_divider: RTL and testbench
================================

# posit_divider

Iterative sequential posit divider producing OUT = IN1 / IN2 for N-bit posits with ES exponent bits. It is the inverse operation of the combinational posit multiplier and sits beside it in the posit arithmetic unit. Operands are accepted on a start/ready handshake, then one quotient bit is computed per cycle. The result is a registered, correctly rounded posit with a one-cycle valid pulse.

## Interface
- N, default 8: posit word width.
- ES, default 3: exponent field width.
- clk  input  1  sole clock, rising edge.
- rst_n  input  1  reset, asynchronous and active-low.
- start  input  1  request; sampled only when in_ready=1.
- IN1  input  N  dividend posit; captured on the accepting edge.
- IN2  input  N  divisor posit; captured on the accepting edge.
- in_ready  output  1  high only in IDLE.
- OUT  output  N  result posit; holds until the next result is written.
- valid  output  1  one-cycle pulse when OUT is updated.

## Operation
- Posit decode:
  - Standard posit format.
  - A negative word is two's-complemented before decoding the regime, exponent and fraction.
  - scale = k·2^ES + e.
- States: IDLE, DECODE, DIV, ROUND.
  - IDLE: if start is high, capture IN1/IN2, go to DECODE. in_ready=1.
  - DECODE: take magnitudes and compute sign = s1^s2 and scale = sc1−sc2. Left-align the mantissas (hidden 1). Special operand: force result, go to ROUND. Otherwise go to DIV.
  - DIV: restoring division, ITER = N+2 cycles, one quotient bit per cycle. The counter runs 0..ITER−1, then the state goes to ROUND.
  - ROUND: normalize, then round and encode. Write OUT, pulse valid, return to IDLE.
- Normalization: the mantissa quotient lies in (0.5, 2). If it is below 1, shift left by 1 and decrement scale.
- Rounding:
  - Round to nearest, ties to even, on the final N-bit encoding.
  - The sticky bit is the OR of the remainder.
- Saturation:
  - Never round a nonzero result to 0 or to NaR.
  - Overflow clamps to ±maxpos (0x7F for N=8). Underflow clamps to ±minpos (0x01).
  - A negative result is the two's complement of the positive encoding.
- Specials:
  - NaR is 1000…0.
  - Either operand NaR → NaR.
  - IN2 = 0 → NaR.
  - IN1 = 0 with IN2 nonzero and not NaR → 0.
- start while not in IDLE is ignored. No queuing.
- Asynchronous reset at any time:
  - state → IDLE; OUT = 0; valid = 0; in_ready = 1.
  - All internal registers are cleared.
  - An in-flight operation is discarded with no valid pulse.

## Timing
- Edge numbering: the edge that samples start is edge 0.
- Normal operation:
  - DECODE occupies edge 1.
  - DIV occupies edges 2..ITER+1.
  - ROUND occupies edge ITER+2, which writes OUT and raises valid. For N=8 that is edge 12.
- Special operands: ROUND is at edge 2, so valid rises after edge 2.
- valid is high for exactly one cycle. OUT is stable from that edge until the next ROUND.
- in_ready is low from edge 0 until the ROUND edge. The next start can be accepted at ROUND edge + 1.
- Throughput: one division per ITER+3 cycles.
- Latency is fixed and independent of operand values, except for the special fast path.

## Structure
- Shared package posit_pkg:
  - default N/ES;
  - localparams ZERO, NAR, MAXPOS, MINPOS as functions of N;
  - state enum;
  - a decoded-posit struct {sign, zero, nar, signed scale, mantissa}.
- Sub-module posit_decoder: combinational, instantiated twice (once per operand), output is the struct.
- Division datapath, normalization, rounding and encoding stay in posit_divider.

## Test plan
- Basic quotients, N=8, ES=3:
  - 0x48/0x44 (4/2) → 0x44.
  - 0x4E/0x46 (12/3) → 0x48.
  - 0x40/0x40 → 0x40.
  - Each: valid after exactly 12 edges, in_ready low during the operation.
- Rounding: 0x40/0x46 (1/3) → 0x39.
- Signs:
  - 0xB8/0x44 (−4/2) → 0xBC.
  - 0xB8/0xBC (−4/−2) → 0x44.
- Specials, each with valid after 2 edges:
  - 0x44/0x00 → 0x80.
  - 0x80/0x44 → 0x80.
  - 0x00/0x44 → 0x00.
- Saturation:
  - 0x7F/0x01 → 0x7F.
  - 0x01/0x7F → 0x01.
  - 0x81/0x01 → 0x81.
- Handshake/reset:
  - start pulsed mid-operation is ignored, and the first result is unchanged.
  - rst_n low at edge 5 of an operation: OUT=0, valid never pulses, in_ready=1 immediately. A new start after release completes normally.

Source files
------------

// File: rtl/posit_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : posit_pkg
//  Description : Shared types and constants for the posit arithmetic unit:
//                default word/exponent widths, special encodings, the
//                divider state enum and the decoded-posit record.
//  Revision    : 1.0  initial release
// ============================================================================
package posit_pkg;

    // Default posit geometry; struct widths below follow these values
    localparam int POSIT_N  = 8;
    localparam int POSIT_ES = 3;

    // Signed scale width: |scale| stays below N*2^ES, the quotient doubles it
    localparam int SCALE_W = $clog2(POSIT_N) + POSIT_ES + 3;

    // Special encodings as functions of the word width
    localparam logic [POSIT_N-1:0] ZERO   = '0;
    localparam logic [POSIT_N-1:0] NAR    = {1'b1, {(POSIT_N-1){1'b0}}};
    localparam logic [POSIT_N-1:0] MAXPOS = {1'b0, {(POSIT_N-1){1'b1}}};
    localparam logic [POSIT_N-1:0] MINPOS = {{(POSIT_N-1){1'b0}}, 1'b1};

    // Divider sequencing
    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_DECODE = 2'd1,
        S_DIV    = 2'd2,
        S_ROUND  = 2'd3
    } state_t;

    // Decoded operand: mantissa is left-aligned with the hidden 1 at the MSB
    typedef struct packed {
        logic                      sign;
        logic                      zero;
        logic                      nar;
        logic signed [SCALE_W-1:0] scale;
        logic [POSIT_N-1:0]        mant;
    } posit_dec_t;

endpackage : posit_pkg
`default_nettype wire

// File: rtl/posit_decoder.sv
`default_nettype none
// ============================================================================
//  Module      : posit_decoder
//  Description : Combinational posit field extraction. Negative words are
//                two's-complemented, then regime, exponent and fraction are
//                split out into a signed scale and a left-aligned mantissa.
//  Revision    : 1.0  initial release
// ============================================================================
module posit_decoder
    import posit_pkg::*;
#(
    parameter int N  = POSIT_N,
    parameter int ES = POSIT_ES
) (
    input  logic [N-1:0] i_word,
    output posit_dec_t   o_dec
);

    logic [N-2:0]  w_body;
    logic [N-2:0]  w_rest;
    logic [N-2:0]  w_frac;
    logic [ES-1:0] w_exp;
    logic          w_r0;
    logic          w_stop;
    int            w_run;
    int            w_k;

    // Take the magnitude, measure the regime run, then peel exponent and fraction
    always_comb begin
        w_body = i_word[N-1] ? (~i_word[N-2:0] + (N-1)'(1)) : i_word[N-2:0];
        w_r0   = w_body[N-2];
        w_run  = 0;
        w_stop = 1'b0;
        for (int i = N - 2; i >= 0; i--) begin
            if (!w_stop && (w_body[i] == w_r0)) begin
                w_run = w_run + 1;
            end else begin
                w_stop = 1'b1;
            end
        end
        w_k = w_r0 ? (w_run - 1) : -w_run;

        // Drop the run and its terminator; truncated exponent bits read as zero
        w_rest = w_body << (w_run + 1);
        w_exp  = w_rest[N-2 -: ES];
        w_frac = w_rest << ES;

        o_dec.sign  = i_word[N-1];
        o_dec.zero  = (i_word == ZERO);
        o_dec.nar   = (i_word == NAR);
        o_dec.scale = SCALE_W'(w_k * (2 ** ES) + int'(w_exp));
        o_dec.mant  = {1'b1, w_frac};
    end

endmodule : posit_decoder
`default_nettype wire

// File: rtl/posit_divider.sv
`default_nettype none
// ============================================================================
//  Module      : posit_divider
//  Description : Iterative posit divider, OUT = IN1 / IN2. One restoring
//                quotient bit per cycle, then normalize, round to nearest
//                even on the final encoding, saturate and encode.
//  Revision    : 1.0  initial release
// ============================================================================
module posit_divider
    import posit_pkg::*;
#(
    parameter int N  = POSIT_N,
    parameter int ES = POSIT_ES
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         start,
    input  logic [N-1:0] IN1,
    input  logic [N-1:0] IN2,
    output logic         in_ready,
    output logic [N-1:0] OUT,
    output logic         valid
);

    // Quotient carries one integer bit plus N+1 fraction bits
    localparam int ITER  = N + 2;
    localparam int CNT_W = $clog2(ITER);
    // Unrounded encoding string: regime field, exponent, fraction
    localparam int STR_W = N + ES + ITER - 1;
    localparam logic [CNT_W-1:0] c_last_cnt = CNT_W'(ITER - 1);

    state_t                    r_state;
    state_t                    w_next;
    logic [N-1:0]              r_in1;
    logic [N-1:0]              r_in2;
    posit_dec_t                w_dec1;
    posit_dec_t                w_dec2;
    logic                      r_sign;
    logic signed [SCALE_W-1:0] r_scale;
    logic [N-1:0]              r_div;
    logic [N:0]                r_rem;
    logic [ITER-1:0]           r_quo;
    logic [CNT_W-1:0]          r_cnt;
    logic                      r_special;
    logic [N-1:0]              r_special_val;
    logic [N-1:0]              r_out;
    logic                      r_valid;

    logic                      w_special;
    logic [N-1:0]              w_special_val;
    logic                      w_ge;
    logic [N-1:0]              w_rem_next;

    logic [ITER-2:0]           w_frac;
    logic signed [SCALE_W-1:0] w_scale;
    logic [ES-1:0]             w_e;
    int                        w_k;
    int                        w_rl;
    logic [N-1:0]              w_regf;
    logic [STR_W-1:0]          w_str;
    logic [N-2:0]              w_body;
    logic                      w_guard;
    logic                      w_sticky;
    logic                      w_rup;
    logic [N-1:0]              w_mag;
    logic [N-1:0]              w_result;

    posit_decoder #(.N(N), .ES(ES)) u_dec1 (
        .i_word (r_in1),
        .o_dec  (w_dec1)
    );

    posit_decoder #(.N(N), .ES(ES)) u_dec2 (
        .i_word (r_in2),
        .o_dec  (w_dec2)
    );

    assign in_ready = (r_state == S_IDLE);
    assign OUT      = r_out;
    assign valid    = r_valid;

    // Operands that bypass the divider: any NaR or a zero divisor give NaR, zero dividend gives 0
    always_comb begin
        w_special     = 1'b0;
        w_special_val = ZERO;
        if (w_dec1.nar || w_dec2.nar || w_dec2.zero) begin
            w_special     = 1'b1;
            w_special_val = NAR;
        end else if (w_dec1.zero) begin
            w_special     = 1'b1;
            w_special_val = ZERO;
        end
    end

    // One restoring step: subtract the divisor when it fits
    always_comb begin
        w_ge       = (r_rem >= {1'b0, r_div});
        w_rem_next = w_ge ? N'(r_rem - {1'b0, r_div}) : r_rem[N-1:0];
    end

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Next-state sequencing
    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:   if (start) w_next = S_DECODE;
            S_DECODE: w_next = w_special ? S_ROUND : S_DIV;
            S_DIV:    if (r_cnt == c_last_cnt) w_next = S_ROUND;
            S_ROUND:  w_next = S_IDLE;
            default:  w_next = S_IDLE;
        endcase
    end

    // Normalize the quotient, build the unbounded encoding and round it to N-1 bits
    always_comb begin
        w_frac   = r_quo[ITER-1] ? r_quo[ITER-2:0] : {r_quo[ITER-3:0], 1'b0};
        w_scale  = r_quo[ITER-1] ? r_scale : (r_scale - SCALE_W'(1));
        w_k      = int'(w_scale) >>> ES;
        w_e      = w_scale[ES-1:0];
        w_rl     = 0;
        w_regf   = '0;
        w_str    = '0;
        w_body   = '0;
        w_guard  = 1'b0;
        w_sticky = 1'b0;
        w_rup    = 1'b0;
        w_mag    = MINPOS;
        if (w_k > N - 3) begin
            w_mag = MAXPOS;
        end else if (w_k < -(N - 2)) begin
            w_mag = MINPOS;
        end else begin
            // Regime is k+1 ones then 0, or -k zeros then 1
            w_rl     = (w_k >= 0) ? (w_k + 2) : (1 - w_k);
            w_regf   = (w_k >= 0) ? N'((1 << w_rl) - 2) : N'(1);
            w_str    = {w_regf, w_e, w_frac} << (N - w_rl);
            w_body   = w_str[STR_W-1 -: N-1];
            w_guard  = w_str[STR_W-N];
            w_sticky = (|w_str[STR_W-N-1:0]) | (|r_rem);
            w_rup    = w_guard & (w_body[0] | w_sticky);
            // Regime always holds a 0 or a 1 inside the body, so this never wraps
            w_mag    = {1'b0, w_body + (N-1)'(w_rup)};
        end
        w_result = r_sign ? (~w_mag + N'(1)) : w_mag;
    end

    // Operand capture, division datapath and result register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_in1         <= '0;
            r_in2         <= '0;
            r_sign        <= 1'b0;
            r_scale       <= '0;
            r_div         <= '0;
            r_rem         <= '0;
            r_quo         <= '0;
            r_cnt         <= '0;
            r_special     <= 1'b0;
            r_special_val <= '0;
            r_out         <= '0;
            r_valid       <= 1'b0;
        end else begin
            r_valid <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_in1 <= IN1;
                        r_in2 <= IN2;
                    end
                end
                S_DECODE: begin
                    r_sign        <= w_dec1.sign ^ w_dec2.sign;
                    r_scale       <= w_dec1.scale - w_dec2.scale;
                    r_rem         <= {1'b0, w_dec1.mant};
                    r_div         <= w_dec2.mant;
                    r_quo         <= '0;
                    r_cnt         <= '0;
                    r_special     <= w_special;
                    r_special_val <= w_special_val;
                end
                S_DIV: begin
                    r_quo <= {r_quo[ITER-2:0], w_ge};
                    r_rem <= {w_rem_next, 1'b0};
                    r_cnt <= r_cnt + CNT_W'(1);
                end
                S_ROUND: begin
                    r_out   <= r_special ? r_special_val : w_result;
                    r_valid <= 1'b1;
                end
                default: ;
            endcase
        end
    end

endmodule : posit_divider
`default_nettype wire

// File: tb/tb_posit_divider.sv
`default_nettype none
// ============================================================================
//  Module      : tb_posit_divider
//  Description : Self-checking bench for posit_divider (N=8, ES=3): directed
//                vector table, handshake/reset sequences and random operands
//                against a value-level reference model.
//  Revision    : 1.0  initial release
// ============================================================================
`timescale 1ns/1ps
module tb_posit_divider;

    localparam int N  = 8;
    localparam int ES = 3;

    logic       clk   = 1'b0;
    logic       rst_n = 1'b0;
    logic       start = 1'b0;
    logic [7:0] in1   = '0;
    logic [7:0] in2   = '0;
    logic       in_ready;
    logic       valid;
    logic [7:0] out_w;

    int checks   = 0;
    int failures = 0;

    typedef struct {
        logic [7:0] a;
        logic [7:0] b;
        logic [7:0] q;
        int         lat;
    } vec_t;

    vec_t       vecs [13];
    logic [7:0] res;
    int         lat;
    bit         busy_ok;
    int         extra;
    logic [7:0] ra;
    logic [7:0] rb;
    logic [7:0] rq;

    always #5 clk = ~clk;

    posit_divider #(.N(N), .ES(ES)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (start),
        .IN1      (in1),
        .IN2      (in2),
        .in_ready (in_ready),
        .OUT      (out_w),
        .valid    (valid)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic real pow2(input int e);
        real r;
        r = 1.0;
        if (e >= 0) begin
            for (int i = 0; i < e; i++) r = r * 2.0;
        end else begin
            for (int i = 0; i < -e; i++) r = r / 2.0;
        end
        return r;
    endfunction

    // Value of a positive n-bit posit (n <= 9) held in the low bits of w
    function automatic real pval(input logic [8:0] w, input int n);
        int  run;
        int  k;
        int  e;
        int  i;
        bit  r0;
        bit  stop;
        real f;
        real wt;
        r0   = w[n-2];
        run  = 0;
        stop = 1'b0;
        for (int j = n - 2; j >= 0; j--) begin
            if (!stop && (w[j] == r0)) run++;
            else stop = 1'b1;
        end
        k = r0 ? run - 1 : -run;
        i = n - 3 - run;
        e = 0;
        for (int j = 0; j < ES; j++) begin
            e = e * 2;
            if (i >= 0) begin
                if (w[i]) e = e + 1;
            end
            i--;
        end
        f  = 1.0;
        wt = 0.5;
        while (i >= 0) begin
            if (w[i]) f = f + wt;
            wt = wt / 2.0;
            i--;
        end
        return f * pow2(k * (1 << ES) + e);
    endfunction

    // Reference: bracket |a/b| between adjacent posits, split at the value of
    // the one-bit-longer pattern {p,1}, ties to the even pattern, clamp at the ends
    function automatic logic [7:0] ref_div(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] ma;
        logic [7:0] mb;
        logic [7:0] r;
        logic [8:0] wm;
        real        av;
        real        bv;
        real        lo;
        real        hi;
        real        mid;
        if (a == 8'h80 || b == 8'h80 || b == 8'h00) return 8'h80;
        if (a == 8'h00) return 8'h00;
        ma = a[7] ? -a : a;
        mb = b[7] ? -b : b;
        av = pval({1'b0, ma}, 8);
        bv = pval({1'b0, mb}, 8);
        r  = 8'h01;
        if (av < pval(9'h001, 8) * bv) begin
            r = 8'h01;
        end else if (av >= pval(9'h07F, 8) * bv) begin
            r = 8'h7F;
        end else begin
            for (int p = 1; p < 127; p++) begin
                lo = pval(9'(p), 8) * bv;
                hi = pval(9'(p + 1), 8) * bv;
                if (av >= lo && av < hi) begin
                    wm  = {p[7:0], 1'b1};
                    mid = pval(wm, 9) * bv;
                    if (av < mid)      r = p[7:0];
                    else if (av > mid) r = 8'(p + 1);
                    else               r = p[0] ? 8'(p + 1) : p[7:0];
                end
            end
        end
        return (a[7] ^ b[7]) ? -r : r;
    endfunction

    // Issue one operation and wait (bounded) for valid; records latency and busy behaviour
    task automatic run_op(input logic [7:0] a, input logic [7:0] b,
                          output logic [7:0] r, output int l, output bit ok);
        @(negedge clk);
        in1   = a;
        in2   = b;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        ok    = 1'b1;
        l     = -1;
        if (in_ready !== 1'b0) ok = 1'b0;
        for (int n = 1; n <= 40; n++) begin
            @(posedge clk);
            #1;
            if (valid === 1'b1) begin
                l = n;
                if (in_ready !== 1'b1) ok = 1'b0;
                break;
            end
            if (in_ready !== 1'b0) ok = 1'b0;
        end
        r = out_w;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        vecs[0]  = '{8'h48, 8'h44, 8'h44, 12};
        vecs[1]  = '{8'h4E, 8'h46, 8'h48, 12};
        vecs[2]  = '{8'h40, 8'h40, 8'h40, 12};
        vecs[3]  = '{8'h40, 8'h46, 8'h39, 12};
        vecs[4]  = '{8'hB8, 8'h44, 8'hBC, 12};
        vecs[5]  = '{8'hB8, 8'hBC, 8'h44, 12};
        vecs[6]  = '{8'h44, 8'h00, 8'h80, 2};
        vecs[7]  = '{8'h80, 8'h44, 8'h80, 2};
        vecs[8]  = '{8'h00, 8'h44, 8'h00, 2};
        vecs[9]  = '{8'h7F, 8'h01, 8'h7F, 12};
        vecs[10] = '{8'h01, 8'h7F, 8'h01, 12};
        vecs[11] = '{8'h81, 8'h01, 8'h81, 12};
        vecs[12] = '{8'h00, 8'h00, 8'h80, 2};

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        check("reset_out", out_w, 8'h00);
        check("reset_valid", valid, 1'b0);
        check("reset_ready", in_ready, 1'b1);
        @(negedge clk);
        rst_n = 1'b1;

        // Directed vectors, plus single-cycle valid and OUT hold one edge later
        for (int t = 0; t < 13; t++) begin
            run_op(vecs[t].a, vecs[t].b, res, lat, busy_ok);
            check($sformatf("vec%0d_out", t), res, vecs[t].q);
            check($sformatf("vec%0d_latency", t), lat, vecs[t].lat);
            check($sformatf("vec%0d_busy", t), busy_ok, 1'b1);
            @(posedge clk);
            #1;
            check($sformatf("vec%0d_valid_pulse", t), valid, 1'b0);
            check($sformatf("vec%0d_out_hold", t), out_w, vecs[t].q);
        end

        // start raised mid-operation is ignored
        @(negedge clk);
        in1   = 8'h48;
        in2   = 8'h44;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        lat   = -1;
        for (int n = 1; n <= 40; n++) begin
            @(posedge clk);
            #1;
            if (n == 3) begin
                in1   = 8'h4E;
                in2   = 8'h46;
                start = 1'b1;
            end
            if (n == 6) start = 1'b0;
            if (valid === 1'b1) begin
                lat = n;
                break;
            end
        end
        start = 1'b0;
        check("midstart_out", out_w, 8'h44);
        check("midstart_latency", lat, 12);
        extra = 0;
        for (int n = 0; n < 15; n++) begin
            @(posedge clk);
            #1;
            if (valid === 1'b1) extra++;
        end
        check("midstart_no_second_result", extra, 0);

        // Asynchronous reset during edge 5 of an operation
        @(negedge clk);
        in1   = 8'h4E;
        in2   = 8'h46;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (5) @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check("abort_out", out_w, 8'h00);
        check("abort_valid", valid, 1'b0);
        check("abort_ready", in_ready, 1'b1);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        extra = 0;
        for (int n = 0; n < 15; n++) begin
            @(posedge clk);
            #1;
            if (valid === 1'b1 || in_ready !== 1'b1) extra++;
        end
        check("abort_no_valid", extra, 0);
        run_op(8'h4E, 8'h46, res, lat, busy_ok);
        check("after_abort_out", res, 8'h48);
        check("after_abort_latency", lat, 12);

        // Random operands against the reference model
        for (int t = 0; t < 250; t++) begin
            ra = 8'($urandom);
            rb = 8'($urandom);
            if (t % 16 == 0) rb = 8'h00;
            if (t % 16 == 1) ra = 8'h00;
            rq = ref_div(ra, rb);
            run_op(ra, rb, res, lat, busy_ok);
            check($sformatf("rand_%02h_%02h_out", ra, rb), res, rq);
            check($sformatf("rand_%02h_%02h_latency", ra, rb), lat,
                  (ra == 8'h00 || rb == 8'h00 || ra == 8'h80 || rb == 8'h80) ? 2 : 12);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule : tb_posit_divider
`default_nettype wire
